// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : Load/store control unit between the execute stage and data_mem.
//             Accepts one request at a time, forms the effective address,
//             maps RV32I funct3 onto data_mem {MemWr, MemOp}, checks funct3
//             legality, alignment (optional) and range, sequences the access
//             and returns load data or a fault through a valid/ready pair.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                     clock, synchronous active-high reset
//    req_valid / req_ready        request handshake (ready only when idle)
//    req_store, req_funct3        operation select and RV32I funct3
//    req_base, req_imm            rs1 value and signed 12-bit offset
//    req_wdata, req_rd            store data and destination register tag
//    mem_addr/wdata/memop/memwr   data_mem Addr/DataIn/MemOp/MemWr
//    mem_rdata                    data_mem DataOut (already extended)
//    resp_valid / resp_ready      response handshake
//    resp_rdata, resp_rd          load result (0 for stores/faults), tag echo
//    resp_fault, resp_fault_code  00 none, 01 misaligned, 10 range, 11 funct3
//  Configuration
//    LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses
//                          fault with code 01; otherwise they pass through.
// ============================================================================
module lsu_ctrl #(
    parameter int DMEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_imm,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_memop,
    output logic        mem_memwr,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic [1:0]  resp_fault_code
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [32:0] c_dmem_bytes = 33'(DMEM_BYTES);
    localparam logic [1:0]  c_code_none  = 2'b00;
    localparam logic [1:0]  c_code_align = 2'b01;
    localparam logic [1:0]  c_code_range = 2'b10;
    localparam logic [1:0]  c_code_func  = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;

    // Registered outputs and latched request fields
    logic        r_req_ready,   w_req_ready_nxt;
    logic [11:0] r_mem_addr,    w_mem_addr_nxt;
    logic [31:0] r_mem_wdata,   w_mem_wdata_nxt;
    logic [2:0]  r_mem_memop,   w_mem_memop_nxt;
    logic        r_mem_memwr,   w_mem_memwr_nxt;
    logic        r_resp_valid,  w_resp_valid_nxt;
    logic [31:0] r_resp_rdata,  w_resp_rdata_nxt;
    logic [4:0]  r_resp_rd,     w_resp_rd_nxt;
    logic        r_resp_fault,  w_resp_fault_nxt;
    logic [1:0]  r_resp_code,   w_resp_code_nxt;
    logic        r_store,       w_store_nxt;

    // ------------------------------------------------------------------
    // Request decode, evaluated on the raw request inputs in IDLE
    // ------------------------------------------------------------------
    logic [31:0] w_ea;
    logic [1:0]  w_size_m1;
    logic [32:0] w_last;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_range;
    logic [1:0]  w_fault_code;
    logic [2:0]  w_memop;

    // Modulo-2^32 add; the carry out is intentionally dropped.
    assign w_ea = req_base + {{20{req_imm[11]}}, req_imm};

    always_comb begin
        w_size_m1 = 2'd0;
        case (req_funct3[1:0])
            2'b01:   w_size_m1 = 2'd1;
            2'b10:   w_size_m1 = 2'd3;
            default: w_size_m1 = 2'd0;
        endcase
    end

    // Last byte touched, in 33 bits so an access wrapping past 2^32 faults.
    assign w_last  = {1'b0, w_ea} + {31'd0, w_size_m1};
    assign w_range = (w_last >= c_dmem_bytes);

    // Loads: 011, 110, 111 illegal. Stores: anything above 010 illegal.
    assign w_illegal = req_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                                 : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && w_ea[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault_code = w_illegal  ? c_code_func  :
                          w_misalign ? c_code_align :
                          w_range    ? c_code_range : c_code_none;

    // Unsigned loads are renumbered onto data_mem's LBU/LHU codes.
    always_comb begin
        w_memop = req_funct3;
        case (req_funct3)
            3'b100:  w_memop = 3'b011;
            3'b101:  w_memop = 3'b100;
            default: w_memop = req_funct3;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next-cycle output values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_req_ready_nxt  = 1'b0;
        w_mem_addr_nxt   = 12'd0;
        w_mem_wdata_nxt  = 32'd0;
        w_mem_memop_nxt  = 3'd0;
        w_mem_memwr_nxt  = 1'b0;
        w_resp_valid_nxt = 1'b0;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_rd_nxt    = r_resp_rd;
        w_resp_fault_nxt = r_resp_fault;
        w_resp_code_nxt  = r_resp_code;
        w_store_nxt      = r_store;

        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (req_valid) begin
                    w_req_ready_nxt  = 1'b0;
                    w_store_nxt      = req_store;
                    w_resp_rd_nxt    = req_rd;
                    w_resp_rdata_nxt = 32'd0;
                    w_resp_fault_nxt = (w_fault_code != c_code_none);
                    w_resp_code_nxt  = w_fault_code;
                    if (w_fault_code != c_code_none) begin
                        w_state_nxt      = S_RESP;
                        w_resp_valid_nxt = 1'b1;
                    end else begin
                        // Memory strobes are loaded here so they are valid
                        // for exactly the one ACCESS cycle.
                        w_state_nxt     = S_ACCESS;
                        w_mem_addr_nxt  = {1'b0, w_ea[10:0]};
                        w_mem_wdata_nxt = req_wdata;
                        w_mem_memop_nxt = w_memop;
                        w_mem_memwr_nxt = req_store;
                    end
                end
            end
            S_ACCESS: begin
                if (r_store) begin
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // data_mem has already extended the value; take it as-is.
                w_state_nxt      = S_RESP;
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = mem_rdata;
            end
            S_RESP: begin
                w_resp_valid_nxt = 1'b1;
                if (resp_ready) begin
                    w_state_nxt      = S_IDLE;
                    w_resp_valid_nxt = 1'b0;
                    w_req_ready_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / field registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready  <= 1'b1;
            r_mem_addr   <= 12'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_memop  <= 3'd0;
            r_mem_memwr  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_rd    <= 5'd0;
            r_resp_fault <= 1'b0;
            r_resp_code  <= 2'd0;
            r_store      <= 1'b0;
        end else begin
            r_req_ready  <= w_req_ready_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_memop  <= w_mem_memop_nxt;
            r_mem_memwr  <= w_mem_memwr_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_rd    <= w_resp_rd_nxt;
            r_resp_fault <= w_resp_fault_nxt;
            r_resp_code  <= w_resp_code_nxt;
            r_store      <= w_store_nxt;
        end
    end

    assign req_ready       = r_req_ready;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign mem_memop       = r_mem_memop;
    assign mem_memwr       = r_mem_memwr;
    assign resp_valid      = r_resp_valid;
    assign resp_rdata      = r_resp_rdata;
    assign resp_rd         = r_resp_rd;
    assign resp_fault      = r_resp_fault;
    assign resp_fault_code = r_resp_code;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Purpose  : Directed self-checking bench for lsu_ctrl with a byte-addressed
//             data_mem model (registered read, extended by MemOp).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [11:0] req_imm;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_memop;
    logic        mem_memwr;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_fault;
    logic [1:0]  resp_fault_code;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.DMEM_BYTES(2048)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_base        (req_base),
        .req_imm         (req_imm),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_memop       (mem_memop),
        .mem_memwr       (mem_memwr),
        .mem_rdata       (mem_rdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_rd         (resp_rd),
        .resp_fault      (resp_fault),
        .resp_fault_code (resp_fault_code)
    );

    // ---------------- data_mem model ----------------
    logic [7:0] tb_mem [0:2047];

    function automatic logic [31:0] mem_load(input logic [10:0] a, input logic [2:0] op);
        logic [7:0] b0, b1, b2, b3;
        b0 = tb_mem[a];
        b1 = tb_mem[a + 11'd1];
        b2 = tb_mem[a + 11'd2];
        b3 = tb_mem[a + 11'd3];
        case (op)
            3'b000:  mem_load = {{24{b0[7]}}, b0};
            3'b001:  mem_load = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_load = {b3, b2, b1, b0};
            3'b011:  mem_load = {24'd0, b0};
            3'b100:  mem_load = {16'd0, b1, b0};
            default: mem_load = 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2048; i++) tb_mem[i] <= 8'h00;
            tb_mem[11'h000] <= 8'h5A;
            tb_mem[11'h104] <= 8'h78; tb_mem[11'h105] <= 8'h56;
            tb_mem[11'h106] <= 8'h34; tb_mem[11'h107] <= 8'h12;
            tb_mem[11'h108] <= 8'h80; tb_mem[11'h109] <= 8'hFF;
            tb_mem[11'h7FC] <= 8'hEF; tb_mem[11'h7FD] <= 8'hBE;
            tb_mem[11'h7FE] <= 8'hAD; tb_mem[11'h7FF] <= 8'hDE;
            mem_rdata <= 32'd0;
        end else begin
            if (mem_memwr) begin
                tb_mem[mem_addr[10:0]] <= mem_wdata[7:0];
                if (mem_memop != 3'b000) tb_mem[mem_addr[10:0] + 11'd1] <= mem_wdata[15:8];
                if (mem_memop == 3'b010) begin
                    tb_mem[mem_addr[10:0] + 11'd2] <= mem_wdata[23:16];
                    tb_mem[mem_addr[10:0] + 11'd3] <= mem_wdata[31:24];
                end
            end
            mem_rdata <= mem_load(mem_addr[10:0], mem_memop);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request with resp_ready high and check the full transaction.
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] base, input logic [11:0] imm,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input logic [11:0] exp_addr, input logic [2:0] exp_op,
                           input logic [1:0] exp_code, input logic [31:0] exp_rdata);
        int lat;
        int exp_lat;
        int wr_cnt;
        logic [31:0] g_rdata;
        logic        g_fault;
        logic [1:0]  g_code;
        logic [4:0]  g_rd;
        exp_lat = (exp_code != 2'b00) ? 1 : (st ? 2 : 3);
        lat = 0; wr_cnt = 0;
        g_rdata = '0; g_fault = 1'b0; g_code = '0; g_rd = '0;
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_base = base; req_imm = imm; req_wdata = wd; req_rd = rd;
        @(posedge clk); #1;
        // Scramble the request inputs; the unit must have latched them.
        req_valid  = 1'b0;
        req_base   = $urandom;
        req_wdata  = $urandom;
        req_imm    = 12'($urandom);
        req_funct3 = 3'($urandom);
        req_store  = 1'($urandom);
        req_rd     = 5'($urandom);
        chk({tag, ".c1_addr"},  32'(mem_addr),  32'(exp_addr));
        chk({tag, ".c1_memop"}, 32'(mem_memop), 32'(exp_op));
        chk({tag, ".c1_memwr"}, 32'(mem_memwr), 32'(st && (exp_code == 2'b00)));
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            if (mem_memwr) wr_cnt++;
            if (resp_valid) begin
                lat = i; g_rdata = resp_rdata; g_fault = resp_fault;
                g_code = resp_fault_code; g_rd = resp_rd;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, ".latency"}, 32'(lat),     32'(exp_lat));
        chk({tag, ".rdata"},   g_rdata,      exp_rdata);
        chk({tag, ".fault"},   32'(g_fault), 32'(exp_code != 2'b00));
        chk({tag, ".code"},    32'(g_code),  32'(exp_code));
        chk({tag, ".rd"},      32'(g_rd),    32'(rd));
        chk({tag, ".wr_cnt"},  32'(wr_cnt),  32'(st && (exp_code == 2'b00)));
        if (lat != 0) begin
            @(posedge clk); #1;
            chk({tag, ".ready_after"}, 32'(req_ready),  32'd1);
            chk({tag, ".valid_after"}, 32'(resp_valid), 32'd0);
        end
    endtask

    localparam logic [1:0] c_exp_ms = `ifdef LSU_MISALIGN_TRAP_EN 2'b01 `else 2'b10 `endif;

    initial begin
        logic [31:0] snap;
        int          waited;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_base = '0; req_imm = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_ready",  32'(req_ready),       32'd1);
        chk("rst.resp_valid", 32'(resp_valid),      32'd0);
        chk("rst.memwr",      32'(mem_memwr),       32'd0);
        chk("rst.addr",       32'(mem_addr),        32'd0);
        chk("rst.rdata",      resp_rdata,           32'd0);
        chk("rst.code",       32'(resp_fault_code), 32'd0);
        rst = 1'b0;

        //      tag       st  f3      base          imm     wdata         rd     addr     op      code   rdata
        run_req("lw_hit", 0, 3'b010, 32'h100,      12'h004, 32'h0,       5'd1,  12'h104, 3'b010, 2'b00, 32'h12345678);
        run_req("lh_neg", 0, 3'b001, 32'h108,      12'h000, 32'h0,       5'd2,  12'h108, 3'b001, 2'b00, 32'hFFFFFF80);
        run_req("lhu",    0, 3'b101, 32'h108,      12'h000, 32'h0,       5'd3,  12'h108, 3'b100, 2'b00, 32'h0000FF80);
        run_req("sb",     1, 3'b000, 32'h200,      12'hFFF, 32'h000000F0,5'd4,  12'h1FF, 3'b000, 2'b00, 32'h0);
        run_req("lb",     0, 3'b000, 32'h200,      12'hFFF, 32'h0,       5'd5,  12'h1FF, 3'b000, 2'b00, 32'hFFFFFFF0);
        run_req("lbu",    0, 3'b100, 32'h200,      12'hFFF, 32'h0,       5'd6,  12'h1FF, 3'b011, 2'b00, 32'h000000F0);
        run_req("lw_top", 0, 3'b010, 32'h7FC,      12'h000, 32'h0,       5'd7,  12'h7FC, 3'b010, 2'b00, 32'hDEADBEEF);
        run_req("lh_top", 0, 3'b001, 32'h7FE,      12'h000, 32'h0,       5'd8,  12'h7FE, 3'b001, 2'b00, 32'hFFFFDEAD);
        run_req("lb_top", 0, 3'b000, 32'h7FF,      12'h000, 32'h0,       5'd9,  12'h7FF, 3'b000, 2'b00, 32'hFFFFFFDE);
        run_req("lb_wrap",0, 3'b000, 32'hFFFFFFFF, 12'h001, 32'h0,       5'd10, 12'h000, 3'b000, 2'b00, 32'h0000005A);
        run_req("lw_oor", 0, 3'b010, 32'h7FE,      12'h000, 32'h0,       5'd11, 12'h000, 3'b000, c_exp_ms, 32'h0);
        run_req("lb_ffff",0, 3'b000, 32'h0,        12'hFFF, 32'h0,       5'd12, 12'h000, 3'b000, 2'b10, 32'h0);
        run_req("sw_oor", 1, 3'b010, 32'h800,      12'h000, 32'h11111111,5'd13, 12'h000, 3'b000, 2'b10, 32'h0);
        run_req("ld_f110",0, 3'b110, 32'h100,      12'h000, 32'h0,       5'd14, 12'h000, 3'b000, 2'b11, 32'h0);
        run_req("ld_f011",0, 3'b011, 32'h100,      12'h000, 32'h0,       5'd15, 12'h000, 3'b000, 2'b11, 32'h0);
        run_req("st_f100",1, 3'b100, 32'h100,      12'h000, 32'h22222222,5'd16, 12'h000, 3'b000, 2'b11, 32'h0);
        run_req("st_f011",1, 3'b011, 32'h100,      12'h000, 32'h33333333,5'd17, 12'h000, 3'b000, 2'b11, 32'h0);
        run_req("ld_f111",0, 3'b111, 32'h0,        12'hFFF, 32'h0,       5'd18, 12'h000, 3'b000, 2'b11, 32'h0);
        // Rejected stores must not have touched memory.
        run_req("lw_chk", 0, 3'b010, 32'h100,      12'h004, 32'h0,       5'd19, 12'h104, 3'b010, 2'b00, 32'h12345678);

        // Backpressure: hold resp_ready low for 5 cycles once the response is up.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_base = 32'h7FC; req_imm = 12'h000; req_rd = 5'd21;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waited = 0;
        while (!resp_valid && waited < 10) begin
            @(posedge clk); #1; waited++;
        end
        chk("bp.valid_seen", 32'(resp_valid), 32'd1);
        snap = resp_rdata;
        chk("bp.rdata", snap, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.hold_valid", 32'(resp_valid), 32'd1);
            chk("bp.hold_rdata", resp_rdata,      32'hDEADBEEF);
            chk("bp.hold_rd",    32'(resp_rd),    32'd21);
            chk("bp.req_ready",  32'(req_ready),  32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.ready_rise", 32'(req_ready),  32'd1);
        chk("bp.valid_drop", 32'(resp_valid), 32'd0);

        // Reset while in CAPTURE drops the response.
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_base = 32'h100; req_imm = 12'h004; req_rd = 5'd22;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rcap.no_valid", 32'(resp_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rcap.req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rcap.quiet", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Misaligned word store.
`ifdef LSU_MISALIGN_TRAP_EN
        run_req("sw_mis", 1, 3'b010, 32'h102, 12'h000, 32'hAABBCCDD, 5'd23, 12'h000, 3'b000, 2'b01, 32'h0);
        run_req("lh_mis", 0, 3'b001, 32'h101, 12'h000, 32'h0,        5'd24, 12'h000, 3'b000, 2'b01, 32'h0);
        run_req("lw_keep",0, 3'b010, 32'h100, 12'h004, 32'h0,        5'd25, 12'h104, 3'b010, 2'b00, 32'h12345678);
`else
        run_req("sw_mis", 1, 3'b010, 32'h102, 12'h000, 32'hAABBCCDD, 5'd23, 12'h102, 3'b010, 2'b00, 32'h0);
        run_req("lw_mis", 0, 3'b010, 32'h102, 12'h000, 32'h0,        5'd24, 12'h102, 3'b010, 2'b00, 32'hAABBCCDD);
        run_req("lw_ovl", 0, 3'b010, 32'h100, 12'h004, 32'h0,        5'd25, 12'h104, 3'b010, 2'b00, 32'h1234AABB);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
